// File: rtl/johnson_pkg.sv
// Shared Johnson (twisted-ring) helpers used by both the counter and the sequence monitor.
// Functions take a max-width code plus the live width n so any N up to JOHNSON_MAX_N works.
package johnson_pkg;

  localparam int JOHNSON_MAX_N = 32;

  typedef logic [JOHNSON_MAX_N-1:0] jcode_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  function automatic int johnson_idx_w(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic jcode_t johnson_next(input jcode_t q, input int n);
    jcode_t r;
    r = '0;
    for (int i = 0; i < JOHNSON_MAX_N; i++) begin
      if (i < n - 1)
        r[i] = q[i+1];
      else if (i == n - 1)
        r[i] = ~q[0];
    end
    return r;
  endfunction

  // Exactly 2n of the 2^n patterns have at most one adjacent-bit transition.
  function automatic logic johnson_legal(input jcode_t q, input int n);
    int t;
    t = 0;
    for (int i = 0; i < JOHNSON_MAX_N - 1; i++) begin
      if (i < n - 1 && q[i] != q[i+1])
        t++;
    end
    return (t <= 1);
  endfunction

  function automatic int johnson_to_idx(input jcode_t q, input int n);
    int   ones;
    int   lz;
    logic found;
    ones  = 0;
    lz    = 0;
    found = 1'b0;
    for (int i = 0; i < JOHNSON_MAX_N; i++) begin
      if (i < n && q[i])
        ones++;
    end
    for (int i = JOHNSON_MAX_N - 1; i >= 0; i--) begin
      if (i < n && !found) begin
        if (q[i])
          found = 1'b1;
        else
          lz++;
      end
    end
    if (!johnson_legal(q, n))
      return 0;
    else if (q[n-1])
      return ones;
    else if (ones == 0)
      return 0;
    else
      return n + lz;
  endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// Combinational Johnson decode: legality flag and binary index (0 when illegal).
module johnson_decode_comb
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = johnson_idx_w(N)
) (
  input  logic [N-1:0]     code,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  jcode_t q;

  always_comb begin
    q          = '0;
    q[N-1:0]   = code;
    legal      = johnson_legal(q, N);
    idx        = IDX_W'(johnson_to_idx(q, N));
  end

endmodule

// File: rtl/johnson_sequence_monitor.sv
// Checks a sampled Johnson code stream for legal patterns and correct succession,
// tracks lock after LOCK_CNT good steps, and keeps a saturating error count.
module johnson_sequence_monitor
  import johnson_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOCK_CNT   = 3,
  parameter int ALLOW_HOLD = 0,
  parameter int ERR_W      = 8,
  localparam int IDX_W     = johnson_idx_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [N-1:0]     code_in,
  input  logic             clear_err,
  output logic [IDX_W-1:0] index_out,
  output logic             index_valid,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2 * N - 1);

  logic             legal;
  logic [IDX_W-1:0] idx;

  lock_state_t      state;
  lock_state_t      state_nxt;
  logic             have_prev;
  logic [IDX_W-1:0] prev_idx;
  logic [IDX_W-1:0] succ_idx;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_nxt;

  logic             code_bad;
  logic             seq_bad;
  logic             step_ok;
  logic             err_evt;

  johnson_decode_comb #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_decode (
    .code  (code_in),
    .legal (legal),
    .idx   (idx)
  );

  assign succ_idx = (prev_idx == IDX_LAST) ? '0 : prev_idx + 1'b1;

  // Classify the current sample; a hold is neither an error nor progress.
  always_comb begin
    code_bad = 1'b0;
    seq_bad  = 1'b0;
    step_ok  = 1'b0;
    if (valid_in) begin
      if (!legal) begin
        code_bad = 1'b1;
      end else if (have_prev) begin
        if (idx == succ_idx)
          step_ok = 1'b1;
        else if (!(ALLOW_HOLD != 0 && idx == prev_idx))
          seq_bad = 1'b1;
      end
    end
  end

  assign err_evt = code_bad | seq_bad;

  always_comb begin
    match_nxt = match_cnt;
    if (err_evt)
      match_nxt = '0;
    else if (step_ok && match_cnt != MATCH_MAX)
      match_nxt = match_cnt + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_UNLOCKED;
    else
      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNLOCKED: if (step_ok && match_nxt == MATCH_MAX) state_nxt = ST_LOCKED;
      ST_LOCKED:   if (err_evt) state_nxt = ST_UNLOCKED;
      default:     state_nxt = ST_UNLOCKED;
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked = (state == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_prev <= 1'b0;
      prev_idx  <= '0;
      match_cnt <= '0;
    end else if (valid_in) begin
      match_cnt <= match_nxt;
      if (legal) begin
        have_prev <= 1'b1;
        prev_idx  <= idx;
      end else begin
        have_prev <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_out   <= '0;
      index_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      index_valid <= valid_in & legal;
      code_err    <= code_bad;
      seq_err     <= seq_bad;
      if (valid_in)
        index_out <= legal ? idx : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_count <= '0;
    else if (clear_err)
      err_count <= '0;
    else if (err_evt && err_count != {ERR_W{1'b1}})
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_johnson_sequence_monitor.sv
// Drives three monitor variants (default, hold-allowed, 2-bit error count) with directed and random
// Johnson streams and compares every output each cycle against a table-driven reference model.
module tb_johnson_sequence_monitor;

  localparam int N  = 4;
  localparam int SL = 2 * N;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic       clear_err;
  logic [3:0] code_in;

  logic [2:0] idx_o [3];
  logic       iv_o  [3];
  logic       ce_o  [3];
  logic       se_o  [3];
  logic       lk_o  [3];
  logic [7:0] ec_a;
  logic [7:0] ec_h;
  logic [1:0] ec_e;

  always #5 clk = ~clk;

  johnson_sequence_monitor #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(0), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in), .code_in(code_in), .clear_err(clear_err),
    .index_out(idx_o[0]), .index_valid(iv_o[0]), .code_err(ce_o[0]), .seq_err(se_o[0]),
    .locked(lk_o[0]), .err_count(ec_a));

  johnson_sequence_monitor #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(1), .ERR_W(8)) dut_h (
    .clk(clk), .reset(reset), .valid_in(valid_in), .code_in(code_in), .clear_err(clear_err),
    .index_out(idx_o[1]), .index_valid(iv_o[1]), .code_err(ce_o[1]), .seq_err(se_o[1]),
    .locked(lk_o[1]), .err_count(ec_h));

  johnson_sequence_monitor #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(0), .ERR_W(2)) dut_e (
    .clk(clk), .reset(reset), .valid_in(valid_in), .code_in(code_in), .clear_err(clear_err),
    .index_out(idx_o[2]), .index_valid(iv_o[2]), .code_err(ce_o[2]), .seq_err(se_o[2]),
    .locked(lk_o[2]), .err_count(ec_e));

  int total = 0;
  int bad   = 0;

  int seq_tab [SL];
  int dec_tab [16];

  int hold_p  [3] = '{0, 1, 0};
  int err_max [3] = '{255, 255, 3};

  int m_have [3], m_prev [3], m_match [3], m_lock [3], m_err [3];
  int e_idx  [3], e_iv   [3], e_ce    [3], e_se   [3];

  string phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s/%s got=%0d want=%0d", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ec_of(input int k);
    case (k)
      0:       return {24'd0, ec_a};
      1:       return {24'd0, ec_h};
      default: return {30'd0, ec_e};
    endcase
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idx%0d", k), {29'd0, idx_o[k]}, e_idx[k]);
      chk($sformatf("iv%0d", k),  {31'd0, iv_o[k]},  e_iv[k]);
      chk($sformatf("ce%0d", k),  {31'd0, ce_o[k]},  e_ce[k]);
      chk($sformatf("se%0d", k),  {31'd0, se_o[k]},  e_se[k]);
      chk($sformatf("lk%0d", k),  {31'd0, lk_o[k]},  m_lock[k]);
      chk($sformatf("ec%0d", k),  ec_of(k),          m_err[k]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_have[k] = 0; m_prev[k] = 0; m_match[k] = 0; m_lock[k] = 0; m_err[k] = 0;
      e_idx[k]  = 0; e_iv[k]   = 0; e_ce[k]    = 0; e_se[k]   = 0;
    end
  endtask

  // Position in the sequence is the index; anything not in the sequence is illegal.
  task automatic model_step(input logic v, input logic [3:0] c, input logic clr);
    int i;
    for (int k = 0; k < 3; k++) begin
      e_iv[k] = 0; e_ce[k] = 0; e_se[k] = 0;
      if (v) begin
        i = dec_tab[c];
        if (i < 0) begin
          e_ce[k] = 1; e_idx[k] = 0;
          m_have[k] = 0; m_match[k] = 0; m_lock[k] = 0;
        end else begin
          e_idx[k] = i; e_iv[k] = 1;
          if (m_have[k] == 0) begin
            m_have[k] = 1;
          end else if (i == (m_prev[k] + 1) % SL) begin
            if (m_match[k] < 3) m_match[k]++;
            if (m_match[k] == 3) m_lock[k] = 1;
          end else if (!(i == m_prev[k] && hold_p[k] == 1)) begin
            e_se[k] = 1; m_match[k] = 0; m_lock[k] = 0;
          end
          m_prev[k] = i;
        end
      end
      if (clr)
        m_err[k] = 0;
      else if ((e_ce[k] || e_se[k]) && m_err[k] < err_max[k])
        m_err[k]++;
    end
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    valid_in  = v;
    code_in   = c;
    clear_err = clr;
    @(posedge clk);
    model_step(v, c, clr);
    @(negedge clk);
    check_all();
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset     = 1'b0;
    valid_in  = 1'b0;
    clear_err = 1'b0;
  endtask

  initial begin
    int c;
    int cur;
    int r;
    logic [3:0] rc;

    for (int j = 0; j < 16; j++) dec_tab[j] = -1;
    c = 0;
    for (int j = 0; j < SL; j++) begin
      seq_tab[j] = c;
      dec_tab[c] = j;
      c = ((~c & 1) << 3) | (c >> 1);
    end

    reset = 1'b1; valid_in = 1'b0; clear_err = 1'b0; code_in = 4'd0;
    model_reset();
    @(negedge clk);
    phase = "reset";
    check_all();
    reset = 1'b0;

    phase = "walk";
    for (int j = 0; j <= SL; j++) step(1'b1, 4'(seq_tab[j % SL]), 1'b0);
    chk("walk_lock", {31'd0, lk_o[0]}, 1);
    chk("walk_err",  {24'd0, ec_a}, 0);

    phase = "illegal";
    step(1'b1, 4'b1010, 1'b0);
    chk("ill_idx", {29'd0, idx_o[0]}, 0);
    step(1'b1, 4'b0011, 1'b0);
    chk("resync_idx", {29'd0, idx_o[0]}, 6);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    chk("relock", {31'd0, lk_o[0]}, 1);

    phase = "skip";
    step(1'b1, 4'b1110, 1'b0);
    chk("skip_se", {31'd0, se_o[0]}, 1);
    step(1'b1, 4'b1111, 1'b0);

    phase = "hold";
    step(1'b1, 4'b0111, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    chk("hold_se_h", {31'd0, se_o[1]}, 0);
    step(1'b1, 4'b0001, 1'b0);

    phase = "sat";
    for (int j = 0; j < 5; j++) step(1'b1, 4'b0101, 1'b0);
    chk("sat_e", {30'd0, ec_e}, 3);
    step(1'b1, 4'b1001, 1'b1);
    chk("clr_e", {30'd0, ec_e}, 0);

    phase = "arst";
    for (int j = 0; j < SL; j++) step(1'b1, 4'(seq_tab[j]), 1'b0);
    async_reset();
    step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b0111, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b1010, 1'b0);
    step(1'b1, 4'b0011, 1'b0);

    phase = "rand";
    cur = 6;
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (n % 200 == 199) begin
        async_reset();
      end else if (r < 55) begin
        cur = (cur + 1) % SL;
        step(1'b1, 4'(seq_tab[cur]), ($urandom_range(0, 19) == 0));
      end else if (r < 65) begin
        step(1'b1, 4'(seq_tab[cur]), 1'b0);
      end else if (r < 75) begin
        rc = 4'($urandom_range(0, 15));
        if (dec_tab[rc] >= 0) cur = dec_tab[rc];
        step(1'b1, rc, 1'b0);
      end else if (r < 85) begin
        cur = $urandom_range(0, SL - 1);
        step(1'b1, 4'(seq_tab[cur]), 1'b0);
      end else begin
        step(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/johnson_sequence_monitor.md
Name: johnson_sequence_monitor

Overview:
Receive-side companion to the team's twisted-ring (Johnson) counter. Samples an N-bit Johnson code each valid cycle and decodes it to a binary index (0..2N-1). Checks that each code is a legal Johnson pattern and the correct successor of the previous one, declares lock after a run of correct steps, and keeps a saturating error count. Sits downstream of any Johnson-counted state bus, such as a clock-domain-crossed pointer or phase counter.

Parameters:
N, 4, Johnson code width in bits; N>=2; sequence length 2N.
LOCK_CNT, 3, consecutive correct successor steps required to assert locked; >=1.
ALLOW_HOLD, 0, 1 = a repeat of the previous code is accepted (no error, no progress).
ERR_W, 8, err_count width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
valid_in  in  1  code_in is sampled this cycle.
code_in  in  N  Johnson code under test.
clear_err  in  1  synchronous clear of err_count.
index_out  out  IDX_W=$clog2(2N)  decoded index of last sampled code.
index_valid  out  1  1-cycle pulse: index_out is from a legal code.
code_err  out  1  1-cycle pulse: illegal pattern sampled.
seq_err  out  1  1-cycle pulse: legal code that is not the expected successor.
locked  out  1  sequence tracking established.
err_count  out  ERR_W  saturating count of code_err plus seq_err events.

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high. Reset sets every output to 0, FSM to UNLOCKED, have_prev=0, prev_idx=0, match_cnt=0.
- Sequence definition matches the counter, with next = {~q[0], q[N-1:1]}. For N=4: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then wrap to 0000.
- Legality: a code is legal iff it has at most one transition between adjacent bits (exactly 2N codes).
- Decode, for legal codes only:
  - q[N-1]=1: idx = popcount(q), range 1..N.
  - q all zero: idx = 0.
  - otherwise: idx = N + count of leading zeros from the MSB, range N+1..2N-1.
- Latency: all outputs are registered, 1 cycle after the sampling edge.
- valid_in=0: all pulses 0; index_out, prev_idx, FSM state, match_cnt and err_count hold.
- valid_in=1 and code illegal:
  - code_err=1, index_valid=0, index_out=0.
  - have_prev<=0, match_cnt<=0, FSM->UNLOCKED.
- valid_in=1 and code legal:
  - index_out=idx, index_valid=1.
  - If have_prev=0: no seq_err, prev_idx<=idx, have_prev<=1, match_cnt unchanged.
  - Else if idx == (prev_idx+1) mod 2N: correct step; match_cnt<=match_cnt+1, saturating at LOCK_CNT.
  - Else if idx == prev_idx and ALLOW_HOLD=1: no error, match_cnt unchanged.
  - Otherwise: seq_err=1, match_cnt<=0, FSM->UNLOCKED.
  - prev_idx<=idx on every legal sample, so the monitor resynchronises to the new position.
- Wrap-around: the step from index 2N-1 to 0 is a correct step.
- FSM states:
  - UNLOCKED -> LOCKED when a correct step brings match_cnt to LOCK_CNT; locked=1 on the same registered edge as that step's index_valid.
  - LOCKED -> UNLOCKED on any code_err or seq_err; locked=0 on the same edge as the error pulse.
- err_count: +1 when code_err or seq_err fires (at most one per cycle); saturates at 2^ERR_W-1.
  - clear_err wins over a simultaneous error: result is 0.
  - clear_err has no effect on lock state.
- Reset mid-operation: immediate return to reset values. The first sample after reset never raises seq_err.

Decomposition:
- Shared package johnson_pkg holds:
  - IDX_W computation, as a function of N.
  - Function johnson_next(code).
  - Function johnson_legal(code).
  - Function johnson_to_idx(code).
  - The counter and this monitor share these functions.
- One natural sub-module: johnson_decode_comb (code_in -> legal, idx), purely combinational.
- The FSM, match counter and error counter live in the top module.

Test Plan (N=4, LOCK_CNT=3, ERR_W=8 unless stated):
1. Reset, then valid_in=1 with 0000,1000,1100,1110,1111,0111,0011,0001,0000 -> index_out 0,1,2,3,4,5,6,7,0 with index_valid each cycle; locked rises with index 3 (1110); no errors across the 0001->0000 wrap; err_count=0.
2. While locked, inject 1010 -> code_err pulse, index_valid=0, index_out=0, locked=0, err_count=1. Next sample 0011 -> index 6, no seq_err; locked again after 3 further correct steps.
3. Skip: 1000 then 1110 -> seq_err pulse, index_out=3, locked=0, err_count+1. Then 1111 counts as a correct step (match_cnt=1).
4. Hold: 1100,1100 with ALLOW_HOLD=0 -> seq_err on the second sample. Same with ALLOW_HOLD=1 -> no error, locked unchanged, match_cnt unchanged.
5. ERR_W=2: five illegal codes -> err_count 1,2,3,3,3. Then clear_err together with an illegal code -> err_count=0 and code_err=1.
6. Assert reset asynchronously mid-cycle while locked -> all outputs 0 immediately. Release, then feed 0111 -> index 5, no seq_err; valid_in=0 gaps between samples -> state held, no pulses.
